// File: rtl/golden_nonce_reporter.sv
// Queues golden nonces in a small FIFO and streams each one out as a 6-byte frame:
// header, nonce bytes MSB first, then an XOR checksum of the four nonce bytes.
module golden_nonce_reporter #(
   parameter int         DEPTH_LOG2 = 2,
   parameter logic [7:0] HEADER     = 8'h55,
   parameter int         DROP_W     = 16
) (
   input  logic                  hash_clk,
   input  logic                  reset,
   input  logic                  nonce_strobe,
   input  logic [31:0]           nonce_in,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic [DEPTH_LOG2:0]   fifo_level,
   output logic [DROP_W-1:0]     drop_count,
   output logic                  busy
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int PW    = DEPTH_LOG2 + 1;

   typedef enum logic [1:0] {IDLE, HDR, DATA, CSUM} state_t;

   state_t              state_reg;
   logic [31:0]         mem [DEPTH];
   logic [PW-1:0]       wr_ptr_reg;
   logic [PW-1:0]       rd_ptr_reg;
   logic [PW-1:0]       level_reg;
   logic [DROP_W-1:0]   drop_reg;
   logic [31:0]         sh_reg;
   logic [7:0]          csum_reg;
   logic [7:0]          data_reg;
   logic [1:0]          idx_reg;
   logic                valid_reg;

   logic empty;
   logic full;
   logic pop;
   logic push;
   logic drop;
   logic handshake;

   // Pointers carry one extra wrap bit so a full FIFO is distinguishable from an empty one.
   assign empty     = (wr_ptr_reg == rd_ptr_reg);
   assign full      = (wr_ptr_reg[PW-1] != rd_ptr_reg[PW-1]) &&
                      (wr_ptr_reg[DEPTH_LOG2-1:0] == rd_ptr_reg[DEPTH_LOG2-1:0]);
   assign pop       = (state_reg == IDLE) && !empty;
   assign push      = nonce_strobe && (!full || pop);
   assign drop      = nonce_strobe && full && !pop;
   assign handshake = valid_reg && tx_ready;

   always_ff @(posedge hash_clk) begin
      if (push)
         mem[wr_ptr_reg[DEPTH_LOG2-1:0]] <= nonce_in;
   end

   always_ff @(posedge hash_clk) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
         drop_reg   <= '0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
         level_reg <= level_reg + PW'(push) - PW'(pop);
         if (drop && (drop_reg != '1))
            drop_reg <= drop_reg + DROP_W'(1);
      end
   end

   always_ff @(posedge hash_clk) begin
      if (reset) begin
         state_reg <= IDLE;
         valid_reg <= 1'b0;
         data_reg  <= 8'h00;
         sh_reg    <= '0;
         csum_reg  <= 8'h00;
         idx_reg   <= 2'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (!empty) begin
                  sh_reg    <= mem[rd_ptr_reg[DEPTH_LOG2-1:0]];
                  csum_reg  <= 8'h00;
                  data_reg  <= HEADER;
                  valid_reg <= 1'b1;
                  state_reg <= HDR;
               end
            end
            HDR: begin
               if (handshake) begin
                  data_reg  <= sh_reg[31:24];
                  csum_reg  <= 8'h00;
                  idx_reg   <= 2'd0;
                  state_reg <= DATA;
               end
            end
            DATA: begin
               // The byte just accepted folds into the checksum; sh always holds it in its top byte.
               if (handshake) begin
                  csum_reg <= csum_reg ^ data_reg;
                  sh_reg   <= {sh_reg[23:0], 8'h00};
                  if (idx_reg != 2'd3) begin
                     data_reg <= sh_reg[23:16];
                     idx_reg  <= idx_reg + 2'd1;
                  end else begin
                     data_reg  <= csum_reg ^ data_reg;
                     state_reg <= CSUM;
                  end
               end
            end
            CSUM: begin
               if (handshake) begin
                  valid_reg <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign tx_data    = data_reg;
   assign tx_valid   = valid_reg;
   assign fifo_level = level_reg;
   assign drop_count = drop_reg;
   assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_golden_nonce_reporter.sv
// Checks two reporter instances (wide and 2-bit drop counters) on shared stimulus
// against a queue-level model of the FIFO and frame stream.
module tb_golden_nonce_reporter;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        nonce_strobe = 1'b0;
   logic [31:0] nonce_in = '0;
   logic        tx_ready = 1'b0;

   logic [7:0]  tx_data,    tx_data_s;
   logic        tx_valid,   tx_valid_s;
   logic [2:0]  fifo_level, fifo_level_s;
   logic [15:0] drop_count;
   logic [1:0]  drop_count_s;
   logic        busy,       busy_s;

   always #5 clk = ~clk;

   golden_nonce_reporter #(.DEPTH_LOG2(2), .HEADER(8'h55), .DROP_W(16)) dut (
      .hash_clk(clk), .reset(reset), .nonce_strobe(nonce_strobe), .nonce_in(nonce_in),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .fifo_level(fifo_level), .drop_count(drop_count), .busy(busy));

   golden_nonce_reporter #(.DEPTH_LOG2(2), .HEADER(8'h55), .DROP_W(2)) dut_sat (
      .hash_clk(clk), .reset(reset), .nonce_strobe(nonce_strobe), .nonce_in(nonce_in),
      .tx_data(tx_data_s), .tx_valid(tx_valid_s), .tx_ready(tx_ready),
      .fifo_level(fifo_level_s), .drop_count(drop_count_s), .busy(busy_s));

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: queue of waiting nonces plus the bytes still to be sent of the current frame.
   int unsigned mq[$];
   byte unsigned mf[$];
   int unsigned mdrop = 0;

   always @(posedge clk) begin : model
      bit do_pop;
      int unsigned n;
      if (reset) begin
         mq.delete();
         mf.delete();
         mdrop = 0;
      end else begin
         do_pop = (mf.size() == 0) && (mq.size() > 0);
         if (mf.size() > 0 && tx_ready)
            void'(mf.pop_front());
         if (do_pop) begin
            n = mq.pop_front();
            mf.push_back(8'h55);
            mf.push_back(n[31:24]);
            mf.push_back(n[23:16]);
            mf.push_back(n[15:8]);
            mf.push_back(n[7:0]);
            mf.push_back(n[31:24] ^ n[23:16] ^ n[15:8] ^ n[7:0]);
         end
         if (nonce_strobe) begin
            if (mq.size() < 4)
               mq.push_back(nonce_in);
            else
               mdrop++;
         end
      end
   end

   bit          prev_stall = 1'b0;
   logic [7:0]  prev_data = '0;
   byte unsigned acc[$];

   always @(negedge clk) begin : compare
      int unsigned exp_drop;
      if (cmp_en) begin
         exp_drop = (mdrop > 65535) ? 65535 : mdrop;
         chk("tx_valid", tx_valid, mf.size() > 0);
         chk("busy", busy, mf.size() > 0);
         chk("fifo_level", fifo_level, mq.size());
         chk("drop_count", drop_count, exp_drop);
         chk("tx_valid_s", tx_valid_s, mf.size() > 0);
         chk("busy_s", busy_s, mf.size() > 0);
         chk("fifo_level_s", fifo_level_s, mq.size());
         chk("drop_count_s", drop_count_s, (mdrop > 3) ? 3 : mdrop);
         if (mf.size() > 0) begin
            chk("tx_data", tx_data, mf[0]);
            chk("tx_data_s", tx_data_s, mf[0]);
         end
         if (prev_stall)
            chk("stall_stable", tx_data, prev_data);
      end
      prev_stall = tx_valid && !tx_ready && !reset;
      prev_data  = tx_data;
      if (tx_valid && tx_ready && !reset)
         acc.push_back(tx_data);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      nonce_strobe = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      acc.delete();
   endtask

   task automatic strobe(input logic [31:0] n);
      nonce_strobe = 1'b1;
      nonce_in = n;
      tick();
      nonce_strobe = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int max);
      int n = 0;
      while ((tx_valid || fifo_level != 0) && n < max) begin
         tick();
         n++;
      end
      chk({name, "_drain"}, tx_valid || (fifo_level != 0), 0);
   endtask

   task automatic chk_bytes(input string name, input byte unsigned exp[$]);
      chk({name, "_len"}, acc.size(), exp.size());
      for (int i = 0; i < exp.size(); i++)
         if (i < acc.size())
            chk(name, acc[i], exp[i]);
   endtask

   function automatic void add_frame(ref byte unsigned q[$], input logic [31:0] n);
      q.push_back(8'h55);
      q.push_back(n[31:24]);
      q.push_back(n[23:16]);
      q.push_back(n[15:8]);
      q.push_back(n[7:0]);
      q.push_back(n[31:24] ^ n[23:16] ^ n[15:8] ^ n[7:0]);
   endfunction

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin : stim
      byte unsigned exp[$];
      int n;
      bit found;
      int ones;

      do_reset();
      cmp_en = 1'b1;
      chk("rst_valid", tx_valid, 0);
      chk("rst_data", tx_data, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_drop", drop_count, 0);
      chk("rst_busy", busy, 0);

      // Single hit with latency pinned by hand.
      tx_ready = 1'b1;
      strobe(32'h1234ABCD);
      chk("lat_t1_valid", tx_valid, 0);
      tick();
      chk("lat_t2_valid", tx_valid, 1);
      chk("lat_t2_hdr", tx_data, 8'h55);
      wait_drain("single", 20);
      exp = '{8'h55, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
      chk_bytes("single_bytes", exp);
      chk("single_drop", drop_count, 0);

      // Back-pressure: ready toggles every cycle.
      do_reset();
      tx_ready = 1'b1;
      strobe(32'h1234ABCD);
      for (int i = 0; i < 30; i++) begin
         tx_ready = ~tx_ready;
         tick();
      end
      tx_ready = 1'b1;
      wait_drain("bp", 20);
      chk_bytes("bp_bytes", exp);
      $display("backpressure frame: %0d bytes", acc.size());

      // Overflow with the consumer stalled.
      do_reset();
      tx_ready = 1'b0;
      for (int k = 1; k <= 6; k++) strobe(k);
      tick();
      chk("ovf_level", fifo_level, 4);
      chk("ovf_drop", drop_count, 1);
      chk("ovf_valid", tx_valid, 1);
      tx_ready = 1'b1;
      wait_drain("ovf", 100);
      exp.delete();
      for (int k = 1; k <= 5; k++) add_frame(exp, k);
      chk_bytes("ovf_bytes", exp);

      // Push lands on the same cycle as a pop while full.
      do_reset();
      tx_ready = 1'b0;
      for (int k = 1; k <= 5; k++) strobe(k);
      chk("col_full", fifo_level, 4);
      tx_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (!busy && fifo_level == 4) found = 1'b1;
      end
      chk("col_found", found, 1);
      nonce_strobe = 1'b1;
      nonce_in = 32'hA5A50001;
      tick();
      nonce_strobe = 1'b0;
      chk("col_level", fifo_level, 4);
      chk("col_drop", drop_count, 0);
      wait_drain("col", 100);
      exp.delete();
      for (int k = 1; k <= 5; k++) add_frame(exp, k);
      add_frame(exp, 32'hA5A50001);
      chk_bytes("col_bytes", exp);

      // Reset after the 8'h34 byte is accepted.
      do_reset();
      tx_ready = 1'b1;
      strobe(32'h1234ABCD);
      strobe(32'hCAFE0001);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (tx_valid && tx_data == 8'h34) found = 1'b1;
      end
      chk("rstmid_found", found, 1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      tick();
      chk("rstmid_valid", tx_valid, 0);
      chk("rstmid_level", fifo_level, 0);
      chk("rstmid_busy", busy, 0);
      reset = 1'b0;
      ones = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (tx_valid) ones++;
      end
      chk("rstmid_quiet", ones, 0);
      exp = '{8'h55, 8'h12, 8'h34};
      chk_bytes("rstmid_bytes", exp);

      // Drop counter saturation on the narrow instance.
      do_reset();
      tx_ready = 1'b0;
      for (int k = 1; k <= 10; k++) strobe(k);
      chk("sat_narrow", drop_count_s, 3);
      chk("sat_wide", drop_count, 5);
      strobe(11);
      strobe(12);
      tick();
      chk("sat_hold", drop_count_s, 3);
      chk("sat_wide2", drop_count, 7);

      // Randomized traffic with varying back-pressure and occasional resets.
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         n = (i / 500) % 3;
         nonce_strobe = ($urandom_range(0, 3) == 0);
         nonce_in = $urandom;
         tx_ready = (n == 0) ? ($urandom_range(0, 9) != 0) :
                    (n == 1) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 9) == 0);
         reset = ($urandom_range(0, 799) == 0);
         tick();
      end
      nonce_strobe = 1'b0;
      reset = 1'b0;
      tx_ready = 1'b1;
      tick();
      wait_drain("rand", 200);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
